// File: rtl/nvdla_package.sv
// Shared TCDM bus widths and small helpers for the NVDLA TCDM arbiter slice.
package nvdla_package;

  localparam int NVDLA_TCDM_AW  = 32;
  localparam int NVDLA_TCDM_DW  = 32;
  localparam int NVDLA_TCDM_BEW = 4;

  // Index width for n items; never zero so single-bit selects stay legal.
  function automatic int nvdla_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nvdla_tcdm_id_fifo.sv
// Outstanding-ID FIFO: remembers which requester owns each granted TCDM transaction.
module nvdla_tcdm_id_fifo
  import nvdla_package::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int PW = nvdla_idx_w(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en;
  logic             pop_en;

  // DEPTH is a power of two, so pointers wrap naturally.
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/nvdla_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among NR requesters, with in-order response routing.
// Optional performance counters are built when NVDLA_TCDM_ARB_PERF_EN is defined.
module nvdla_tcdm_rr_arbiter
  import nvdla_package::*;
#(
  parameter int NR        = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  input  logic [NR-1:0]                        s_req_i,
  output logic [NR-1:0]                        s_gnt_o,
  input  logic [NR-1:0][NVDLA_TCDM_AW-1:0]     s_add_i,
  input  logic [NR-1:0]                        s_wen_i,
  input  logic [NR-1:0][NVDLA_TCDM_BEW-1:0]    s_be_i,
  input  logic [NR-1:0][NVDLA_TCDM_DW-1:0]     s_data_i,
  output logic [NVDLA_TCDM_DW-1:0]             s_r_data_o,
  output logic [NR-1:0]                        s_r_valid_o,
  output logic                                 m_req_o,
  input  logic                                 m_gnt_i,
  output logic [NVDLA_TCDM_AW-1:0]             m_add_o,
  output logic                                 m_wen_o,
  output logic [NVDLA_TCDM_BEW-1:0]            m_be_o,
  output logic [NVDLA_TCDM_DW-1:0]             m_data_o,
  input  logic [NVDLA_TCDM_DW-1:0]             m_r_data_i,
  input  logic                                 m_r_valid_i,
  output logic                                 err_o
`ifdef NVDLA_TCDM_ARB_PERF_EN
  ,
  output logic [NR-1:0][31:0]                  perf_gnt_cnt_o,
  output logic [31:0]                          perf_stall_cnt_o
`endif
);

  localparam int IW = nvdla_idx_w(NR);
  localparam int CW = $clog2(MAX_OUTST) + 1;

  // Handshake: a transaction transfers in the cycle where m_req_o and m_gnt_i are both high;
  // m_req_o never drops or changes requester while waiting for m_gnt_i, and every transfer
  // is answered later by exactly one m_r_valid_i pulse, in issue order.

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] lock_sel_q;
  logic          lock_q;
  logic          err_q;
  logic [IW-1:0] sel;
  logic          any_req;
  logic          full;
  logic          m_req;
  logic          grant;
  logic          resp_hit;
  logic [IW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] ptr, input logic [NR-1:0] req);
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic          hit;
    pick = ptr;
    hit  = 1'b0;
    idx  = ptr;
    for (int i = 0; i < NR; i++) begin
      if (!hit && req[idx]) begin
        pick = idx;
        hit  = 1'b1;
      end
      idx = (idx == IW'(NR - 1)) ? '0 : idx + 1'b1;
    end
    return pick;
  endfunction

  // A stalled request keeps its owner until the master grants it.
  assign sel     = lock_q ? lock_sel_q : rr_pick(ptr_q, s_req_i);
  assign any_req = |s_req_i;
  assign full    = fifo_full;
  assign m_req   = any_req & ~full;
  assign grant   = m_req & m_gnt_i;
  assign m_req_o = m_req;

  assign m_add_o  = m_req ? s_add_i[sel]  : '0;
  assign m_wen_o  = m_req ? s_wen_i[sel]  : 1'b0;
  assign m_be_o   = m_req ? s_be_i[sel]   : '0;
  assign m_data_o = m_req ? s_data_i[sel] : '0;

  assign resp_hit    = m_r_valid_i & (fifo_count != '0);
  assign s_r_data_o  = resp_hit ? m_r_data_i : '0;
  assign err_o       = err_q;

  always_comb begin
    s_gnt_o     = '0;
    s_r_valid_o = '0;
    if (grant)    s_gnt_o[sel]           = 1'b1;
    if (resp_hit) s_r_valid_o[fifo_head] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
    end else if (clear_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= m_req & ~m_gnt_i;
      lock_sel_q <= sel;
      if (grant) ptr_q <= (sel == IW'(NR - 1)) ? '0 : sel + 1'b1;
      // A response with nothing outstanding is dropped and flagged until reset/clear.
      if (m_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  nvdla_tcdm_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IW)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .push_i      (grant),
    .push_data_i (sel),
    .pop_i       (resp_hit),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

`ifdef NVDLA_TCDM_ARB_PERF_EN
  logic [NR-1:0][31:0] gnt_cnt_q;
  logic [31:0]         stall_cnt_q;
  logic                stall_evt;

  // The two stall sources are exclusive: full already forces m_req low.
  assign stall_evt = (m_req & ~m_gnt_i) | (any_req & full);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (clear_i) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (grant && (sel == IW'(r)) && (gnt_cnt_q[r] != '1))
          gnt_cnt_q[r] <= gnt_cnt_q[r] + 32'd1;
      end
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_gnt_cnt_o   = gnt_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nvdla_tcdm_rr_arbiter.sv
// Directed bench for nvdla_tcdm_rr_arbiter with an owner scoreboard; perf checks need NVDLA_TCDM_ARB_PERF_EN.
module tb_nvdla_tcdm_rr_arbiter;

  localparam int NR = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                clear;
  logic [NR-1:0]       s_req;
  logic [NR-1:0]       s_gnt;
  logic [NR-1:0][31:0] s_add;
  logic [NR-1:0]       s_wen;
  logic [NR-1:0][3:0]  s_be;
  logic [NR-1:0][31:0] s_data;
  logic [31:0]         s_r_data;
  logic [NR-1:0]       s_r_valid;
  logic                m_req;
  logic                m_gnt;
  logic [31:0]         m_add;
  logic                m_wen;
  logic [3:0]          m_be;
  logic [31:0]         m_data;
  logic [31:0]         m_r_data;
  logic                m_r_valid;
  logic                err;
`ifdef NVDLA_TCDM_ARB_PERF_EN
  logic [NR-1:0][31:0] perf_gnt_cnt;
  logic [31:0]         perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [NR-1:0] exp_q[$];
  logic [31:0]   rdata;

  nvdla_tcdm_rr_arbiter #(.NR(NR), .MAX_OUTST(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .s_req_i     (s_req),
    .s_gnt_o     (s_gnt),
    .s_add_i     (s_add),
    .s_wen_i     (s_wen),
    .s_be_i      (s_be),
    .s_data_i    (s_data),
    .s_r_data_o  (s_r_data),
    .s_r_valid_o (s_r_valid),
    .m_req_o     (m_req),
    .m_gnt_i     (m_gnt),
    .m_add_o     (m_add),
    .m_wen_o     (m_wen),
    .m_be_o      (m_be),
    .m_data_o    (m_data),
    .m_r_data_i  (m_r_data),
    .m_r_valid_i (m_r_valid),
    .err_o       (err)
`ifdef NVDLA_TCDM_ARB_PERF_EN
    ,
    .perf_gnt_cnt_o   (perf_gnt_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
    s_req     = req;
    m_gnt     = gnt;
    m_r_valid = rv;
    m_r_data  = rd;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  task automatic sb_push(input logic [NR-1:0] owner);
    exp_q.push_back(owner);
  endtask

  task automatic sb_resp(input string tag, input logic [31:0] data_exp);
    logic [NR-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=response expected=queued owner", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_vld"}, 32'(s_r_valid), 32'(e));
      check({tag, "_data"}, s_r_data, data_exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    s_add = '0;
    s_wen = '0;
    s_be = '0;
    s_data = '0;
    drive('0, 1'b0, 1'b0, '0);

    // reset state
    @(negedge clk);
    check("rst_gnt", 32'(s_gnt), 0);
    check("rst_rvld", 32'(s_r_valid), 0);
    check("rst_rdata", s_r_data, 0);
    check("rst_mreq", 32'(m_req), 0);
    check("rst_err", 32'(err), 0);
    step();
    rst = 1'b0;

    // single read from requester 0, answered next cycle
    s_add[0] = 32'h100; s_wen = 2'b01; s_be[0] = 4'hF; s_data[0] = 32'h1234_5678;
    drive(2'b01, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("t1_mreq", 32'(m_req), 1);
    check("t1_madd", m_add, 32'h100);
    check("t1_mwen", 32'(m_wen), 1);
    check("t1_mbe", 32'(m_be), 32'hF);
    check("t1_mdata", m_data, 32'h1234_5678);
    check("t1_gnt", 32'(s_gnt), 32'b01);
    sb_push(2'b01);
    step();
    drive(2'b00, 1'b0, 1'b1, 32'hCAFE);
    @(negedge clk);
    sb_resp("t1_resp", 32'hCAFE);
    check("t1_idle_madd", m_add, 0);
    check("t1_idle_mreq", 32'(m_req), 0);
    step();

    // soft clear resets the pointer
    drive(2'b00, 1'b0, 1'b0, '0);
    clear = 1'b1;
    @(negedge clk);
    check("clr_gnt", 32'(s_gnt), 0);
    step();
    clear = 1'b0;

    // both requesters, grant always: alternate 0,1,0,1 with overlapped responses
    s_add[0] = 32'h200; s_add[1] = 32'h300;
    drive(2'b11, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("t2_gnt0", 32'(s_gnt), 32'b01);
    sb_push(2'b01);
    step();
    for (int k = 1; k < 4; k++) begin
      rdata = 32'($urandom_range(32'hFFFF, 0));
      drive(2'b11, 1'b1, 1'b1, rdata);
      @(negedge clk);
      sb_resp("t2_resp", rdata);
      check("t2_gnt", 32'(s_gnt), (k % 2 == 1) ? 32'b10 : 32'b01);
      sb_push((k % 2 == 1) ? 2'b10 : 2'b01);
      step();
    end
    rdata = 32'($urandom_range(32'hFFFF, 0));
    drive(2'b00, 1'b0, 1'b1, rdata);
    @(negedge clk);
    sb_resp("t2_last", rdata);
    step();

    // lock: req1 stalled three cycles, req0 rises meanwhile (pointer is at 0)
    s_wen = 2'b10;
    drive(2'b10, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("t3_mreq", 32'(m_req), 1);
    check("t3_madd_a", m_add, 32'h300);
    check("t3_gnt_a", 32'(s_gnt), 0);
    step();
    drive(2'b11, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("t3_madd_b", m_add, 32'h300);
    step();
    @(negedge clk);
    check("t3_madd_c", m_add, 32'h300);
    step();
    drive(2'b11, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("t3_gnt_d", 32'(s_gnt), 32'b10);
    check("t3_wen_d", 32'(m_wen), 1);
    sb_push(2'b10);
    step();
    drive(2'b01, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("t3_gnt_e", 32'(s_gnt), 32'b01);
    check("t3_madd_e", m_add, 32'h200);
    check("t3_wen_e", 32'(m_wen), 0);
    sb_push(2'b01);
    step();
    for (int k = 0; k < 2; k++) begin
      rdata = 32'($urandom_range(32'hFFFF, 0));
      drive(2'b00, 1'b0, 1'b1, rdata);
      @(negedge clk);
      sb_resp("t3_resp", rdata);
      step();
    end

    // FIFO full: four grants, then m_req drops; no bypass on the popping cycle
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 1'b1, 1'b0, '0);
      @(negedge clk);
      check("t4_gnt", 32'(s_gnt), 32'b01);
      sb_push(2'b01);
      step();
    end
    @(negedge clk);
    check("t4_full_mreq", 32'(m_req), 0);
    check("t4_full_gnt", 32'(s_gnt), 0);
    step();
    rdata = 32'($urandom_range(32'hFFFF, 0));
    drive(2'b01, 1'b1, 1'b1, rdata);
    @(negedge clk);
    check("t4_nobypass_mreq", 32'(m_req), 0);
    sb_resp("t4_resp_pop", rdata);
    step();
    drive(2'b01, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("t4_reassert_mreq", 32'(m_req), 1);
    check("t4_reassert_gnt", 32'(s_gnt), 32'b01);
    sb_push(2'b01);
    step();
    for (int k = 0; k < 4; k++) begin
      rdata = 32'($urandom_range(32'hFFFF, 0));
      drive(2'b00, 1'b0, 1'b1, rdata);
      @(negedge clk);
      sb_resp("t4_drain", rdata);
      step();
    end

    // stray response with FIFO empty
    drive(2'b00, 1'b0, 1'b1, 32'h5A);
    @(negedge clk);
    check("t5_rvld", 32'(s_r_valid), 0);
    check("t5_err_pre", 32'(err), 0);
    step();
    drive(2'b00, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("t5_err_set", 32'(err), 1);
    step();
    @(negedge clk);
    check("t5_err_hold", 32'(err), 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t5_err_rst", 32'(err), 0);
    step();
    rst = 1'b0;

    // clear mid-operation discards the outstanding ID
    drive(2'b01, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("t5b_gnt", 32'(s_gnt), 32'b01);
    step();
    drive(2'b00, 1'b0, 1'b0, '0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 32'h77);
    @(negedge clk);
    check("t5b_rvld", 32'(s_r_valid), 0);
    step();
    drive(2'b00, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("t5b_err", 32'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;

`ifdef NVDLA_TCDM_ARB_PERF_EN
    // 10 grants to req0, 5 to req1, 3 stall cycles
    for (int k = 0; k < 10; k++) begin
      drive(2'b01, 1'b1, (k > 0), 32'h0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      drive(2'b10, 1'b1, 1'b1, 32'h0);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 1'b0, (k == 0), 32'h0);
      step();
    end
    drive(2'b00, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("t6_gnt0", perf_gnt_cnt[0], 10);
    check("t6_gnt1", perf_gnt_cnt[1], 5);
    check("t6_stall", perf_stall_cnt, 3);
    step();
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
